morse_key_encoder: RTL



---
 rtl/morse_key_encoder_if.sv | 18 +
 rtl/morse_key_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_encoder_if.sv
// Morse encoder bus: raw key in, symbol code and status out.
// master = encoder side (key in; dr, code_valid, sym_count, key_led out); slave = key/display side.
interface morse_key_encoder_if;
    logic       key;
    logic [9:0] dr;
    logic       code_valid;
    logic [2:0] sym_count;
    logic       key_led;

    modport master (
        input  key,
        output dr, code_valid, sym_count, key_led
    );
    modport slave (
        output key,
        input  dr, code_valid, sym_count, key_led
    );
endinterface

// File: rtl/morse_key_encoder.sv
// Morse key encoder: sync + debounce key, classify dots/dashes, emit letter/space codes.
// Ports: clk, rst_n (sync, active low), bus (master: key in; dr/code_valid/sym_count/key_led out).
// Optional: define LONG_PRESS_CLEAR_EN to abort a letter on a press of CLEAR_TICKS ticks.
module morse_key_encoder #(
    parameter int TICK_DIV    = 100000,
    parameter int DEB_TICKS   = 10,
    parameter int DOT_MAX     = 200,
    parameter int LETTER_GAP  = 400,
    parameter int WORD_GAP    = 1200,
    parameter int CLEAR_TICKS = 3000
) (
    input  logic                clk,
    input  logic                rst_n,
    morse_key_encoder_if.master bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [9:0] C_BLANK = 10'b0000000001;
    localparam logic [9:0] C_ERR   = 10'b0000000010;
    localparam logic [9:0] C_WSP   = 10'b0000000011;

    if (TICK_DIV < 2 || WORD_GAP <= LETTER_GAP || CLEAR_TICKS < 1) begin : g_bad_params
        $error("morse_key_encoder: illegal parameters");
    end

    typedef enum logic [1:0] {IDLE, PRESS, GAP, WAIT_WORD} state_t;

    state_t        state_q, state_d;
    logic          ks1_q, ks2_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          led_q, led_d;
    logic [15:0]   dur_q, dur_d, gap_q, gap_d;
    logic [9:0]    buf_q, buf_d, dr_q, dr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d, vld_q, vld_d;
    logic          tick, rise, fall, let_hit, word_hit;
    logic          clr_hit, abort_w;
    logic [15:0]   dur_sat, gap_sat;
    logic [1:0]    sym;

    assign tick = (tick_q == TW'(TICK_DIV - 1));

    // Input conditioning: tick prescaler and debounce toward the synced key.
    always_comb begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        deb_d  = deb_q;
        led_d  = led_q;
        if (ks2_q == led_q) begin
            deb_d = '0;
        end else if (tick) begin
            if (deb_q == DW'(DEB_TICKS - 1)) begin
                deb_d = '0;
                led_d = ~led_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    // Edges are seen in the cycle the debounced level flips.
    assign rise     = led_d & ~led_q;
    assign fall     = ~led_d & led_q;
    assign dur_sat  = (dur_q == 16'hFFFF) ? dur_q : dur_q + 16'd1;
    assign gap_sat  = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;
    assign let_hit  = tick && (gap_q == 16'(LETTER_GAP - 1));
    assign word_hit = tick && (gap_q == 16'(WORD_GAP - 1));
    assign sym      = (dur_q < 16'(DOT_MAX)) ? 2'b01 : 2'b11;

`ifdef LONG_PRESS_CLEAR_EN
    logic abort_q, abort_d;
    assign clr_hit = (state_q == PRESS) && tick
                     && (dur_q == 16'(CLEAR_TICKS - 1));
    assign abort_w = abort_q | clr_hit;
    assign abort_d = (state_q == PRESS) ? abort_w : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) abort_q <= 1'b0;
        else        abort_q <= abort_d;
    end
`else
    assign clr_hit = 1'b0;
    assign abort_w = 1'b0;
`endif

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ks1_q   <= 1'b0;
            ks2_q   <= 1'b0;
            tick_q  <= '0;
            deb_q   <= '0;
            led_q   <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dr_q    <= C_BLANK;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ks1_q   <= bus.key;
            ks2_q   <= ks1_q;
            tick_q  <= tick_d;
            deb_q   <= deb_d;
            led_q   <= led_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dr_q    <= dr_d;
            vld_q   <= vld_d;
        end
    end

    // Next state: a key rise always beats a gap threshold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rise) state_d = PRESS;
            PRESS: if (fall) state_d = abort_w ? IDLE : GAP;
            GAP: begin
                if (rise)         state_d = PRESS;
                else if (let_hit) state_d = WAIT_WORD;
            end
            WAIT_WORD: begin
                if (rise)          state_d = PRESS;
                else if (word_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath next values.
    always_comb begin
        dur_d = dur_q;
        gap_d = gap_q;
        buf_d = buf_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        dr_d  = dr_q;
        vld_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    dur_d = '0;
                    buf_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            PRESS: begin
                if (tick) dur_d = dur_sat;
                if (clr_hit) begin
                    buf_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    dr_d  = C_BLANK;
                    vld_d = 1'b1;
                end
                if (fall && !abort_w) begin
                    if (cnt_q < 3'd4) begin
                        unique case (cnt_q[1:0])
                            2'd0:    buf_d[3:2] = sym;
                            2'd1:    buf_d[5:4] = sym;
                            2'd2:    buf_d[7:6] = sym;
                            default: buf_d[9:8] = sym;
                        endcase
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    gap_d = '0;
                end
            end
            GAP: begin
                if (tick) gap_d = gap_sat;
                if (rise) begin
                    dur_d = '0;
                end else if (let_hit) begin
                    dr_d  = ovf_q ? C_ERR : {buf_q[9:2], 2'b00};
                    vld_d = 1'b1;
                end
            end
            WAIT_WORD: begin
                if (tick) gap_d = gap_sat;
                if (rise) begin
                    dur_d = '0;
                    buf_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (word_hit) begin
                    dr_d  = C_WSP;
                    vld_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.dr         = dr_q;
    assign bus.code_valid = vld_q;
    assign bus.sym_count  = cnt_q;
    assign bus.key_led    = led_q;
endmodule
